branch_predict_redirect: RTL and testbench

Consumer side of branch resolution in the 64-bit RISC-V pipeline. Predicts conditional branches in ID from a table of 2-bit saturating counters and redirects fetch early on predicted-taken. It takes the EX-stage taken/not-taken result from the branch comparator, trains the table, and on mispredict issues the corrective PC plus IF/ID and ID/EX flushes. It also keeps saturating branch and mispredict statistics.

---
 rtl/branch_pkg.sv | 19 +
 rtl/branch_history_table.sv | 31 +++
 rtl/branch_predict_redirect.sv | 108 ++++++++++
 tb/tb_branch_predict_redirect.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for branch prediction and resolution.
package branch_pkg;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t   BHT_CTR_RESET = 2'b01;
    localparam logic [2:0] F3_BEQ        = 3'b000;
    localparam logic [2:0] F3_BLT        = 3'b100;
    localparam int         INSN_BYTES    = 4;

    // 2-bit saturating counter step: taken counts up, not-taken counts down.
    function automatic bht_ctr_t bht_next(input bht_ctr_t c, input logic taken);
        if (taken)
            return (c == 2'b11) ? c : c + 2'd1;
        else
            return (c == 2'b00) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// Array of 2-bit saturating counters: one combinational read port, one
// synchronous update port. A same-index read in the update cycle sees the old value.
module branch_history_table
    import branch_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [IDX_W-1:0] i_rd_idx,
    output bht_ctr_t         o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    bht_ctr_t r_ctr [ENTRIES];

    assign o_rd_ctr = r_ctr[i_rd_idx];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < ENTRIES; i++)
                r_ctr[i] <= BHT_CTR_RESET;
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= bht_next(r_ctr[i_wr_idx], i_wr_taken);
        end
    end

endmodule

// File: rtl/branch_predict_redirect.sv
// ID-stage branch prediction with early fetch redirect, EX-stage resolution,
// training and statistics. Define BRANCH_PREDICT_EN to enable the predictor.
module branch_predict_redirect
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int XLEN        = 64
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_id_valid,
    input  logic            i_id_is_branch,
    input  logic            i_id_stall,
    input  logic [XLEN-1:0] i_id_pc,
    input  logic [XLEN-1:0] i_id_imm,
    output logic            o_id_pred_taken,
    output logic            o_id_redirect,
    output logic [XLEN-1:0] o_id_target,
    input  logic            i_ex_valid,
    input  logic            i_ex_is_branch,
    input  logic            i_ex_taken,
    input  logic            i_ex_pred_taken,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic [XLEN-1:0] i_ex_imm,
    output logic            o_ex_redirect,
    output logic [XLEN-1:0] o_ex_redirect_pc,
    output logic            o_flush_if_id,
    output logic            o_flush_id_ex,
    output logic [31:0]     o_branch_count,
    output logic [31:0]     o_mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic        w_resolve;
    logic        w_mispredict;
    logic [31:0] r_branch_count;
    logic [31:0] r_mispredict_count;

    assign w_resolve        = i_ex_valid && i_ex_is_branch;
    assign w_mispredict     = w_resolve && (i_ex_taken != i_ex_pred_taken);
    assign o_ex_redirect    = w_mispredict;
    assign o_ex_redirect_pc = i_ex_taken ? i_ex_pc + i_ex_imm
                                         : i_ex_pc + XLEN'(INSN_BYTES);
    assign o_flush_id_ex    = w_mispredict;

`ifdef BRANCH_PREDICT_EN
    logic     r_issued;
    bht_ctr_t w_rd_ctr;
    logic     w_pred;
    logic     w_unused_ctr_lsb;

    branch_history_table #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_rd_idx   (i_id_pc[IDX_W+1:2]),
        .o_rd_ctr   (w_rd_ctr),
        .i_wr_en    (w_resolve),
        .i_wr_idx   (i_ex_pc[IDX_W+1:2]),
        .i_wr_taken (i_ex_taken)
    );

    assign w_unused_ctr_lsb = w_rd_ctr[0];
    assign w_pred           = i_id_valid && i_id_is_branch && w_rd_ctr[1];
    assign o_id_pred_taken  = w_pred;
    // An EX mispredict squashes the ID instruction, so its redirect is dropped.
    assign o_id_redirect    = w_pred && !w_mispredict && !r_issued;
    assign o_id_target      = i_id_pc + i_id_imm;
    assign o_flush_if_id    = w_mispredict || o_id_redirect;

    // Remembers that a stalled branch already redirected, so it fires only once.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_issued <= 1'b0;
        else if (w_mispredict || !i_id_stall)
            r_issued <= 1'b0;
        else if (o_id_redirect)
            r_issued <= 1'b1;
    end
`else
    logic w_unused;

    assign w_unused        = ^{i_id_valid, i_id_is_branch, i_id_stall, i_id_pc, i_id_imm};
    assign o_id_pred_taken = 1'b0;
    assign o_id_redirect   = 1'b0;
    assign o_id_target     = '0;
    assign o_flush_if_id   = w_mispredict;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_resolve && r_branch_count != 32'hFFFF_FFFF)
                r_branch_count <= r_branch_count + 32'd1;
            if (w_mispredict && r_mispredict_count != 32'hFFFF_FFFF)
                r_mispredict_count <= r_mispredict_count + 32'd1;
        end
    end

    assign o_branch_count     = r_branch_count;
    assign o_mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predict_redirect.sv
// Directed self-checking bench for branch_predict_redirect; expectations
// follow the BRANCH_PREDICT_EN setting of the build.
module tb_branch_predict_redirect;

`ifdef BRANCH_PREDICT_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_is_branch, id_stall;
    logic [63:0] id_pc, id_imm;
    logic        id_pred_taken, id_redirect;
    logic [63:0] id_target;
    logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
    logic [63:0] ex_pc, ex_imm;
    logic        ex_redirect;
    logic [63:0] ex_redirect_pc;
    logic        flush_if_id, flush_id_ex;
    logic [31:0] branch_count, mispredict_count;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_br  = 0;
    logic [31:0] exp_mis = 0;

    always #5 clk = ~clk;

    branch_predict_redirect #(.BHT_ENTRIES(16), .XLEN(64)) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_id_valid         (id_valid),
        .i_id_is_branch     (id_is_branch),
        .i_id_stall         (id_stall),
        .i_id_pc            (id_pc),
        .i_id_imm           (id_imm),
        .o_id_pred_taken    (id_pred_taken),
        .o_id_redirect      (id_redirect),
        .o_id_target        (id_target),
        .i_ex_valid         (ex_valid),
        .i_ex_is_branch     (ex_is_branch),
        .i_ex_taken         (ex_taken),
        .i_ex_pred_taken    (ex_pred_taken),
        .i_ex_pc            (ex_pc),
        .i_ex_imm           (ex_imm),
        .o_ex_redirect      (ex_redirect),
        .o_ex_redirect_pc   (ex_redirect_pc),
        .o_flush_if_id      (flush_if_id),
        .o_flush_id_ex      (flush_id_ex),
        .o_branch_count     (branch_count),
        .o_mispredict_count (mispredict_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic v, input logic [63:0] pc, input logic [63:0] imm,
                          input logic taken, input logic pred);
        ex_valid = v; ex_is_branch = v; ex_pc = pc; ex_imm = imm;
        ex_taken = taken; ex_pred_taken = pred;
    endtask

    task automatic id_set(input logic v, input logic [63:0] pc, input logic [63:0] imm,
                          input logic stall);
        id_valid = v; id_is_branch = v; id_pc = pc; id_imm = imm; id_stall = stall;
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, ".branch_count"}, {32'd0, branch_count}, {32'd0, exp_br});
        chk({tag, ".mispredict_count"}, {32'd0, mispredict_count}, {32'd0, exp_mis});
    endtask

    initial begin
        reset = 1'b1;
        id_set(1'b0, 64'h0, 64'h0, 1'b0);
        ex_set(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        #2;
        chk("rst.ex_redirect", {63'd0, ex_redirect}, 64'd0);
        chk("rst.id_redirect", {63'd0, id_redirect}, 64'd0);
        chk("rst.flush_if_id", {63'd0, flush_if_id}, 64'd0);
        chk("rst.flush_id_ex", {63'd0, flush_id_ex}, 64'd0);
        chk_stats("rst");
        tick();
        reset = 1'b0;

        // First mispredict out of reset: static not-taken, actually taken
        ex_set(1'b1, 64'h40, 64'h80, 1'b1, 1'b0);
        #1;
        chk("mp1.ex_redirect", {63'd0, ex_redirect}, 64'd1);
        chk("mp1.redirect_pc", ex_redirect_pc, 64'hC0);
        chk("mp1.flush_if_id", {63'd0, flush_if_id}, 64'd1);
        chk("mp1.flush_id_ex", {63'd0, flush_id_ex}, 64'd1);
        tick();
        exp_br = 1; exp_mis = 1;
        chk_stats("mp1");

        // Second taken resolve, predicted correctly: counter 10 -> 11
        ex_set(1'b1, 64'h40, 64'h80, 1'b1, 1'b1);
        #1;
        chk("ok1.ex_redirect", {63'd0, ex_redirect}, 64'd0);
        chk("ok1.flush_id_ex", {63'd0, flush_id_ex}, 64'd0);
        tick();
        exp_br = 2;
        chk_stats("ok1");

        ex_set(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        id_set(1'b1, 64'h40, 64'h20, 1'b0);
        #1;
        chk("idp.pred_taken", {63'd0, id_pred_taken}, {63'd0, PE});
        chk("idp.id_redirect", {63'd0, id_redirect}, {63'd0, PE});
        chk("idp.id_target", id_target, PE ? 64'h60 : 64'h0);
        chk("idp.flush_if_id", {63'd0, flush_if_id}, {63'd0, PE});
        chk("idp.flush_id_ex", {63'd0, flush_id_ex}, 64'd0);

        // EX mispredict in the same cycle wins over the ID redirect
        ex_set(1'b1, 64'h100, 64'h10, 1'b0, 1'b1);
        #1;
        chk("pri.ex_redirect", {63'd0, ex_redirect}, 64'd1);
        chk("pri.redirect_pc", ex_redirect_pc, 64'h104);
        chk("pri.id_redirect", {63'd0, id_redirect}, 64'd0);
        chk("pri.flush_if_id", {63'd0, flush_if_id}, 64'd1);
        chk("pri.flush_id_ex", {63'd0, flush_id_ex}, 64'd1);
        tick();
        exp_br = 3; exp_mis = 2;
        chk_stats("pri");

        // Stalled predicted-taken branch redirects once (index 0 now holds 10)
        ex_set(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        id_set(1'b1, 64'h40, 64'h20, 1'b1);
        #1;
        chk("stall.c1", {63'd0, id_redirect}, {63'd0, PE});
        tick();
        chk("stall.c2", {63'd0, id_redirect}, 64'd0);
        chk("stall.c2_pred", {63'd0, id_pred_taken}, {63'd0, PE});
        tick();
        chk("stall.c3", {63'd0, id_redirect}, 64'd0);
        id_stall = 1'b0;
        #1;
        chk("stall.release", {63'd0, id_redirect}, 64'd0);
        tick();
        chk("stall.next_branch", {63'd0, id_redirect}, {63'd0, PE});
        tick();

        // Saturation on index 1 (pc 0x44): 5 taken, then not-taken steps down
        id_set(1'b0, 64'h0, 64'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            ex_set(1'b1, 64'h44, 64'h8, 1'b1, 1'b1);
            tick();
        end
        exp_br = 8;
        ex_set(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        id_set(1'b1, 64'h44, 64'h8, 1'b0);
        #1;
        chk("sat.pred_11", {63'd0, id_pred_taken}, {63'd0, PE});
`ifdef BRANCH_PREDICT_EN
        chk("sat.ctr_11", {62'd0, dut.u_bht.r_ctr[1]}, 64'd3);
`endif
        ex_set(1'b1, 64'h44, 64'h8, 1'b0, 1'b0);
        #1;
        chk("sat.same_cycle_old", {63'd0, id_pred_taken}, {63'd0, PE});
        tick();
        ex_set(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        #1;
        chk("sat.pred_10", {63'd0, id_pred_taken}, {63'd0, PE});
`ifdef BRANCH_PREDICT_EN
        chk("sat.ctr_10", {62'd0, dut.u_bht.r_ctr[1]}, 64'd2);
`endif
        ex_set(1'b1, 64'h44, 64'h8, 1'b0, 1'b0);
        tick();
        ex_set(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        #1;
        chk("sat.pred_01", {63'd0, id_pred_taken}, 64'd0);
        exp_br = 10;
        chk_stats("sat");
        id_set(1'b0, 64'h0, 64'h0, 1'b0);

        // Mispredict statistic holds at all-ones
        force dut.r_mispredict_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_mispredict_count;
        ex_set(1'b1, 64'h80, 64'h40, 1'b1, 1'b0);
        #1;
        chk("msat.redirect_pc", ex_redirect_pc, 64'hC0);
        tick();
        exp_br = 11; exp_mis = 32'hFFFF_FFFF;
        chk_stats("msat");

        // Asynchronous reset in the middle of a stalled predicted-taken branch
        ex_set(1'b1, 64'h48, 64'h4, 1'b1, 1'b0);
        id_set(1'b1, 64'h40, 64'h20, 1'b1);
        #1;
        chk("mrst.pre_ex", {63'd0, ex_redirect}, 64'd1);
        #2;
        reset = 1'b1;
        ex_set(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        #1;
        exp_br = 0; exp_mis = 0;
        chk("mrst.pred_taken", {63'd0, id_pred_taken}, 64'd0);
        chk("mrst.id_redirect", {63'd0, id_redirect}, 64'd0);
        chk("mrst.ex_redirect", {63'd0, ex_redirect}, 64'd0);
        chk("mrst.flush_if_id", {63'd0, flush_if_id}, 64'd0);
        chk("mrst.flush_id_ex", {63'd0, flush_id_ex}, 64'd0);
        chk_stats("mrst");
`ifdef BRANCH_PREDICT_EN
        for (int i = 0; i < 16; i++)
            chk($sformatf("mrst.ctr%0d", i), {62'd0, dut.u_bht.r_ctr[i]}, 64'd1);
`endif
        tick();
        reset = 1'b0;
        id_set(1'b0, 64'h0, 64'h0, 1'b0);

        // One taken step from the reset value 01 already predicts taken
        ex_set(1'b1, 64'h40, 64'h20, 1'b1, 1'b1);
        tick();
        ex_set(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        id_set(1'b1, 64'h40, 64'h20, 1'b0);
        #1;
        chk("post.pred_taken", {63'd0, id_pred_taken}, {63'd0, PE});
        exp_br = 1;
        chk_stats("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
